// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory port arbiter.
//   state_e  : arbiter FSM states (IDLE / ISSUE / RDATA)
//   req_id_e : requester identifiers (CPU = 0, DMA = 1)
//   DEF_DATA_W / DEF_ADDR_W : default memory data and address widths
package mem_arb_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RDATA = 2'b10
  } state_e;

  typedef enum logic {
    CPU = 1'b0,
    DMA = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational 2-way round-robin pick.
//   req[1:0] in  : request vector, bit 0 = CPU, bit 1 = DMA
//   last     in  : requester that won the previous grant
//   winner   out : selected requester (meaningful only while valid)
//   valid    out : at least one request is active
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_e    last,
  output req_id_e    winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = CPU;
    if (req == 2'b11) begin
      // Tie: the requester that did not win last time goes next.
      winner = (last == CPU) ? DMA : CPU;
    end else if (req[1]) begin
      winner = DMA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between a CPU and a DMA
// requester using round-robin arbitration.
//   clk, reset                      : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata           : CPU request, held until cpu_gnt is seen
//   dma_req/we/addr/wdata           : DMA request, same protocol
//   cpu_gnt, dma_gnt                : one-cycle grant pulse (ISSUE cycle)
//   cpu_rvalid, dma_rvalid          : one-cycle read-data-valid pulse (RDATA)
//   rdata                           : read data, valid only with an rvalid
//   mem_addr, mem_wdata, mem_we     : registered memory command
//   mem_rdata                       : memory read data, one cycle after address
//   busy                            : high whenever the FSM is not in IDLE
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              cpu_gnt,
  output logic              dma_gnt,
  output logic              cpu_rvalid,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e            state_q, state_d;
  req_id_e           last_winner_q, last_winner_d;
  req_id_e           owner_q, owner_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              dma_gnt_q, dma_gnt_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              dma_rvalid_q, dma_rvalid_d;

  req_id_e           pick_winner;
  logic              pick_valid;

  rr_pick2 u_pick (
    .req    ({dma_req, cpu_req}),
    .last   (last_winner_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    owner_d       = owner_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_we_d      = 1'b0;
    cpu_gnt_d     = 1'b0;
    dma_gnt_d     = 1'b0;
    cpu_rvalid_d  = 1'b0;
    dma_rvalid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d       = ISSUE;
          owner_d       = pick_winner;
          last_winner_d = pick_winner;
          if (pick_winner == DMA) begin
            mem_we_d    = dma_we;
            mem_addr_d  = dma_addr;
            mem_wdata_d = dma_wdata;
            dma_gnt_d   = 1'b1;
          end else begin
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            cpu_gnt_d   = 1'b1;
          end
        end
      end
      ISSUE: begin
        // mem_we_q still carries the latched write-enable during ISSUE.
        if (mem_we_q) begin
          state_d = IDLE;
        end else begin
          state_d      = RDATA;
          cpu_rvalid_d = (owner_q == CPU);
          dma_rvalid_d = (owner_q == DMA);
        end
      end
      RDATA: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_winner_q <= DMA;
      owner_q       <= CPU;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
      cpu_gnt_q     <= 1'b0;
      dma_gnt_q     <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      dma_rvalid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      owner_q       <= owner_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
      cpu_gnt_q     <= cpu_gnt_d;
      dma_gnt_q     <= dma_gnt_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      dma_rvalid_q  <= dma_rvalid_d;
    end
  end

  // Synchronous memory data only arrives during RDATA, so rdata is a gated
  // pass-through rather than a register; it reads as zero otherwise.
  always_comb begin
    rdata = '0;
    if (cpu_rvalid_q || dma_rvalid_q) begin
      rdata = mem_rdata;
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign dma_gnt    = dma_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dma_rvalid = dma_rvalid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: DATA_W, default 16, memory data width.
REQ-002 Parameter: ADDR_W, default 16, memory address width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port: clk  in  1  single clock; all logic updates on its rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: cpu_req  in  1  processor access request, held until cpu_gnt is sampled high.
REQ-007 Port: cpu_we / cpu_addr / cpu_wdata  in  1/ADDR_W/DATA_W  processor write-enable, address and write data.
REQ-008 Port: dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  second requester, with the same meaning as the processor ports.
REQ-009 Port: cpu_gnt, dma_gnt  out  1 each  one-cycle grant pulse; at most one is high.
REQ-010 Port: cpu_rvalid, dma_rvalid  out  1 each  one-cycle read-data-valid pulse.
REQ-011 Port: rdata  out  DATA_W  read data, shared by both requesters, valid only while an rvalid is high.
REQ-012 Port: mem_addr, mem_wdata, mem_we  out  ADDR_W/DATA_W/1  memory command, registered.
REQ-013 Port: mem_rdata  in  DATA_W  synchronous memory read data, valid one cycle after the address is presented.
REQ-014 Port: busy  out  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, ISSUE, RDATA.
REQ-016 IDLE: if any req is high at the edge, the block SHALL pick a winner and latch its we/addr/wdata into the mem_* registers, then go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-017 req inputs SHALL be sampled only in IDLE; requests raised or dropped in other states have no effect until IDLE.
REQ-018 ISSUE: the winner's gnt SHALL be high for exactly this cycle; mem_we SHALL equal the latched we for this cycle only.
REQ-019 ISSUE -> IDLE when latched we=1; ISSUE -> RDATA when we=0.
REQ-020 RDATA: the winner's rvalid SHALL be high and rdata SHALL equal mem_rdata; next state IDLE.
REQ-021 Latency from req sampled to gnt is 1 cycle; to rvalid is 2 cycles. Writes occupy 2 cycles per access, reads 3.
REQ-022 Arbitration SHALL be 2-way round-robin on a last_winner bit. When one requester is active it wins. When both are active, the requester other than last_winner wins.
REQ-023 last_winner SHALL update only on a grant.
REQ-024 With both requesters permanently active, grants SHALL strictly alternate; no requester waits more than one foreign access.
REQ-025 A requester SHALL drop req on the edge at which it samples gnt high. A req still high in the following IDLE is a new request, so back-to-back access is allowed.
REQ-026 mem_addr and mem_wdata SHALL hold their values outside ISSUE.
REQ-027 mem_we SHALL be 0 in IDLE and RDATA.

Reset
REQ-028 Reset SHALL set state=IDLE and last_winner=dma, so the processor wins the first tie.
REQ-029 Reset SHALL force all gnt, rvalid and mem_we outputs to 0, and busy to 0.
REQ-030 Reset SHALL set mem_addr=0, mem_wdata=0 and rdata=0.
REQ-031 Reset asserted mid-access, in ISSUE or RDATA, SHALL abort the access with no gnt/rvalid pulse on the following cycle. It has priority over all transitions.

Structure
REQ-032 Package mem_arb_pkg SHALL hold the state encoding (IDLE=2'b00, ISSUE=2'b01, RDATA=2'b10), the requester IDs (CPU=0, DMA=1) and the default widths.
REQ-033 Sub-module rr_pick2 SHALL be combinational: inputs req[1:0] and last; outputs winner and valid. The FSM and registers live in mem_port_arbiter.

Verification
REQ-034 Single cpu read, addr=0x0010, memory preloaded 0xBEEF: cpu_gnt in cycle 1, cpu_rvalid with rdata=0xBEEF in cycle 2, busy low in cycle 3.
REQ-035 Single dma write, addr=0x0020, wdata=0x1234: dma_gnt and mem_we=1 with mem_addr=0x0020 for one cycle; the memory then holds 0x1234; no rvalid.
REQ-036 Both requesting writes from reset for 4 accesses: grant order cpu, dma, cpu, dma, with one IDLE cycle between them.
REQ-037 Reset asserted during RDATA of a cpu read: no cpu_rvalid appears, state=IDLE, and all outputs are 0 on the next cycle.
REQ-038 dma_req pulsed high only during ISSUE of a cpu access, then low: it is never granted, and busy returns low.
REQ-039 cpu_req held high across 3 reads while dma is idle: gnts on cycles 1, 4 and 7, and each rvalid one cycle after its gnt.
